// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice stepped LSB-first over WIDTH bits.
// Optional subtract mode (sub port) when SERIAL_ADD_CTRL_SUB_EN is defined.
`timescale 1ns/1ps
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_CTRL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n, sb, sb_n, res, res_n, sum_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             carry, carry_n, cout_n, busy_n, done_n;
  logic             s_bit, c_bit;
  logic [WIDTH-1:0] res_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      res   <= res_n;
      cnt   <= cnt_n;
      carry <= carry_n;
      sum   <= sum_n;
      cout  <= cout_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state, datapath step and flag decode; busy/done are registered from next state.
  always_comb begin
    state_n   = state;
    sa_n      = sa;
    sb_n      = sb;
    res_n     = res;
    cnt_n     = cnt;
    carry_n   = carry;
    sum_n     = sum;
    cout_n    = cout;
    s_bit     = sa[0] ^ sb[0] ^ carry;
    c_bit     = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
    res_shift = (res >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    case (state)
      IDLE: begin
        if (start) begin
          sa_n  = a;
`ifdef SERIAL_ADD_CTRL_SUB_EN
          sb_n    = sub ? ~b : b;
          carry_n = sub;
`else
          sb_n    = b;
          carry_n = 1'b0;
`endif
          res_n   = '0;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        sa_n    = sa >> 1;
        sb_n    = sb >> 1;
        res_n   = res_shift;
        carry_n = c_bit;
        cnt_n   = cnt + CW'(1);
        if (cnt == LAST) begin
          sum_n   = res_shift;
          cout_n  = c_bit;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8), including the
// subtract cases when SERIAL_ADD_CTRL_SUB_EN is defined.
`timescale 1ns/1ps
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic       sub;
`endif

  int passed = 0;
  int total  = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pulse start, then wait (bounded) for done; reports busy cycles and edges to done.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       output int busy_cnt, output int lat);
    a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = 0;
    lat = 0;
    while (!done && lat < 50) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  int  bc, lt, npulse;
  logic held;
  logic [7:0] ta [3];
  logic [7:0] tb [3];
  logic [7:0] ts [3];
  logic       tc [3];

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    sub = 1'b0;
`endif
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum",  32'(sum),  0);
    chk("rst_cout", 32'(cout), 0);
    rst_n = 1'b1;
    step();

    // Basic add
    do_op(8'h3C, 8'h42, bc, lt);
    chk("basic_busy_cycles", 32'(bc), 8);
    chk("basic_latency", 32'(lt), 8);
    chk("basic_done", 32'(done), 1);
    chk("basic_sum", 32'(sum), 32'h7E);
    chk("basic_cout", 32'(cout), 0);
    step();
    chk("basic_done_single", 32'(done), 0);

    // Wrap and hold
    do_op(8'hFF, 8'h01, bc, lt);
    chk("wrap_latency", 32'(lt), 8);
    chk("wrap_sum", 32'(sum), 32'h00);
    chk("wrap_cout", 32'(cout), 1);
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      step();
      if (sum !== 8'h00 || cout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) held = 1'b0;
    end
    chk("wrap_hold", 32'(held), 1);

    // Start while busy is ignored
    a = 8'h01; b = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    a = 8'h80; b = 8'h80; start = 1'b1;
    step();
    start = 1'b0;
    npulse = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) npulse++;
    end
    chk("busy_ign_pulses", 32'(npulse), 1);
    chk("busy_ign_sum", 32'(sum), 32'h02);
    chk("busy_ign_cout", 32'(cout), 0);
    chk("busy_ign_idle", 32'(busy), 0);

    // Async reset mid-RUN
    a = 8'hAA; b = 8'h55; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("arst_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_sum",  32'(sum),  0);
    chk("arst_cout", 32'(cout), 0);
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) npulse++;
    end
    chk("arst_no_resume", 32'(npulse), 0);
    chk("arst_sum_after", 32'(sum), 0);
    do_op(8'h10, 8'h20, bc, lt);
    chk("arst_fresh_sum", 32'(sum), 32'h30);
    chk("arst_fresh_cout", 32'(cout), 0);
    step();

    // Back-to-back with start held high
    ta[0] = 8'h12; tb[0] = 8'h34; ts[0] = 8'h46; tc[0] = 1'b0;
    ta[1] = 8'hF0; tb[1] = 8'h20; ts[1] = 8'h10; tc[1] = 1'b1;
    ta[2] = 8'h7F; tb[2] = 8'h7F; ts[2] = 8'hFE; tc[2] = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = ta[k]; b = tb[k];
      step();
      for (int j = 1; j <= 9; j++) begin
        a = 8'($urandom); b = 8'($urandom);
        step();
        if (j == 8) begin
          chk($sformatf("b2b_done_%0d", k), 32'(done), 1);
          chk($sformatf("b2b_sum_%0d", k), 32'(sum), 32'(ts[k]));
          chk($sformatf("b2b_cout_%0d", k), 32'(cout), 32'(tc[k]));
        end
      end
      chk($sformatf("b2b_idle_%0d", k), 32'(busy | done), 0);
    end
    start = 1'b0;
    step(); step();

`ifdef SERIAL_ADD_CTRL_SUB_EN
    sub = 1'b1;
    do_op(8'h10, 8'h01, bc, lt);
    chk("sub_pos_sum", 32'(sum), 32'h0F);
    chk("sub_pos_cout", 32'(cout), 1);
    step();
    do_op(8'h01, 8'h02, bc, lt);
    chk("sub_neg_sum", 32'(sum), 32'hFF);
    chk("sub_neg_cout", 32'(cout), 0);
    step();
    sub = 1'b0;
    do_op(8'h01, 8'h02, bc, lt);
    chk("sub_off_sum", 32'(sum), 32'h03);
    chk("sub_off_cout", 32'(cout), 0);
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
